// File: rtl/if_prefetch_buffer.sv
// Instruction-fetch prefetch buffer: one outstanding req/ack fetch, PC-tagged FIFO, stall and redirect.
// Optional IF_PREFETCH_PERF_EN adds perf_fetched / perf_flushed counters.
module if_prefetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instr_valid
`ifdef IF_PREFETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_flushed
`endif
);

  localparam int          AW      = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, WAIT, DISCARD} state_t;

  state_t        state_reg, state_next;
  logic [31:0]   fetch_pc_reg, fetch_pc_next;
  logic [31:0]   req_addr_reg;
  logic [AW-1:0] rd_ptr_reg, wr_ptr_reg;
  logic [AW:0]   count_reg;
  logic [31:0]   pc_mem    [DEPTH];
  logic [31:0]   instr_mem [DEPTH];
  logic          issue, push, pop;

  // Only IDLE issues, so nothing is outstanding and count alone bounds occupancy.
  assign issue       = (state_reg == IDLE) && !redirect && (count_reg < DEPTH_C);
  assign push        = (state_reg == WAIT) && imem_ack && !redirect;
  assign instr_valid = (count_reg != '0);
  assign pop         = instr_valid && !stall && !redirect;
  assign instr       = instr_valid ? instr_mem[rd_ptr_reg] : '0;
  assign pc          = instr_valid ? pc_mem[rd_ptr_reg] : '0;

  // A request cannot be withdrawn, so after issue the address comes from the latched copy.
  assign imem_req  = !reset && (issue || (state_reg != IDLE));
  assign imem_addr = (state_reg == IDLE) ? fetch_pc_reg : req_addr_reg;

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (issue) state_next = WAIT;
      WAIT: begin
        if (imem_ack)      state_next = IDLE;
        else if (redirect) state_next = DISCARD;
      end
      DISCARD: if (imem_ack) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    fetch_pc_next = fetch_pc_reg;
    if (redirect)
      fetch_pc_next = {redirect_pc[31:2], 2'b00};
    else if (push)
      fetch_pc_next = fetch_pc_reg + 32'd4;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      fetch_pc_reg <= RESET_PC;
      req_addr_reg <= RESET_PC;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      count_reg    <= '0;
    end else begin
      state_reg    <= state_next;
      fetch_pc_reg <= fetch_pc_next;
      if (issue)
        req_addr_reg <= fetch_pc_reg;
      if (redirect) begin
        rd_ptr_reg <= '0;
        wr_ptr_reg <= '0;
        count_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
        if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
        if (push && !pop)
          count_reg <= count_reg + 1'b1;
        else if (!push && pop)
          count_reg <= count_reg - 1'b1;
      end
    end
  end

  // Payload storage carries no reset; validity is tracked by count_reg.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem[wr_ptr_reg]    <= fetch_pc_reg;
      instr_mem[wr_ptr_reg] <= imem_rdata;
    end
  end

`ifdef IF_PREFETCH_PERF_EN
  logic drop;
  assign drop = imem_ack && ((state_reg == DISCARD) || ((state_reg == WAIT) && redirect));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= '0;
      perf_flushed <= '0;
    end else begin
      if (push)
        perf_fetched <= perf_fetched + 32'd1;
      perf_flushed <= perf_flushed + (redirect ? 32'(count_reg) : 32'd0) + 32'(drop);
    end
  end
`endif

endmodule
